lbus_slave_v3: RTL and testbench

- Parametrised local-bus (PLX-style nADS/nREADY/nBTERM/nBLAST) slave front end for the SURF readout path.
- Decodes NUM_WIN chip-select windows and supports read and write bursts on any window, with per-window burst enable.
- Generates auto-incrementing backend addresses, a programmable backend read latency, a MAX_BURST limit and a stuck-transfer timeout.
- Sits between the bus pins and the register, housekeeping and LAB RAM backends. Bus tristating lives outside this block.

---
 rtl/lbus_slave_v3.sv | 253 +++++++++++++++++++++++++
 tb/tb_lbus_slave_v3.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbus_slave_v3.sv
// Local-bus (nADS/nREADY/nBTERM/nBLAST) slave front end.
// Bus pins are registered once on entry; every decision works on the
// registered copies. Every output is a flop. The FSM drives backend
// read/write strobes and auto-increments the backend address across
// burst beats. A stuck-transfer timeout aborts to IDLE and sets a
// sticky error flag.
// Handshake: a bus beat completes on the single clock where nready_o is
// low. nbterm_o, when asserted, is low on that same clock. Backend
// strobes (be_rd_o, be_wr_o) are single-clock pulses qualified by
// be_addr_o. There is no backpressure from the backend.
module lbus_slave_v3 #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int NUM_WIN   = 3,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255,
  localparam int WIN_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               nads_i,
  input  logic               wnr_i,
  input  logic               nblast_i,
  input  logic [NUM_WIN-1:0] ncs_i,
  input  logic [ADDR_W-1:0]  la_i,
  input  logic [DATA_W-1:0]  ld_i,
  output logic [DATA_W-1:0]  ld_o,
  output logic               ld_oe_o,
  output logic               nready_o,
  output logic               nbterm_o,
  input  logic [NUM_WIN-1:0] burst_en_i,
  output logic [WIN_W-1:0]   win_o,
  output logic [ADDR_W-1:0]  be_addr_o,
  output logic               be_rd_o,
  input  logic [DATA_W-1:0]  be_rdat_i,
  output logic               be_wr_o,
  output logic [DATA_W-1:0]  be_wdat_o,
  output logic               err_o,
  input  logic               err_clr_i
);

  localparam int BEAT_W = $clog2(MAX_BURST);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int LAT_W  = 3;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_BEAT, WR_BEAT, WR_COMMIT
  } state_t;

  // Registered bus inputs
  logic               nads_q, wnr_q, nblast_q;
  logic [NUM_WIN-1:0] ncs_q;
  logic [ADDR_W-1:0]  la_q;
  logic [DATA_W-1:0]  ld_q;

  // FSM state and registered outputs
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic               ld_oe_q, ld_oe_d;
  logic               nready_q, nready_d;
  logic               nbterm_q, nbterm_d;
  logic               be_rd_q, be_rd_d;
  logic               be_wr_q, be_wr_d;
  logic               err_q, err_d;

  // Decode helpers
  logic               cs_any;
  logic [WIN_W-1:0]   win_sel;
  logic               burst_new;
  logic               burst_cur;
  logic [BEAT_W-1:0]  beat_nx;
  logic               term_cond;
  logic               term_next;

  // Capture bus pins once; active-low strobes reset to inactive
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      nads_q   <= 1'b1;
      wnr_q    <= 1'b0;
      nblast_q <= 1'b1;
      ncs_q    <= '1;
      la_q     <= '0;
      ld_q     <= '0;
    end else begin
      nads_q   <= nads_i;
      wnr_q    <= wnr_i;
      nblast_q <= nblast_i;
      ncs_q    <= ncs_i;
      la_q     <= la_i;
      ld_q     <= ld_i;
    end
  end

  // Lowest-index active chip select picks the window; look up burst enables
  always_comb begin
    cs_any    = 1'b0;
    win_sel   = '0;
    burst_new = 1'b0;
    burst_cur = 1'b0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (!ncs_q[i]) begin
        cs_any  = 1'b1;
        win_sel = WIN_W'(i);
      end
    end
    for (int i = 0; i < NUM_WIN; i++) begin
      if (win_sel == WIN_W'(i)) burst_new = burst_en_i[i];
      if (win_q == WIN_W'(i))   burst_cur = burst_en_i[i];
    end
    beat_nx   = beat_q + 1'b1;
    term_cond = !burst_cur || (beat_q == BEAT_W'(MAX_BURST - 1));
    term_next = !burst_cur || (beat_nx == BEAT_W'(MAX_BURST - 1));
  end

  // Next-state and next-output logic; the timeout abort overrides everything
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    win_d    = win_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    rdata_d  = rdata_q;
    wdat_d   = wdat_q;
    ld_oe_d  = ld_oe_q;
    nready_d = 1'b1;
    nbterm_d = 1'b1;
    be_rd_d  = 1'b0;
    be_wr_d  = 1'b0;
    err_d    = err_clr_i ? 1'b0 : err_q;
    tmo_d    = (state_q == IDLE || !nready_q) ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!nads_q && cs_any) begin
          addr_d = la_q;
          win_d  = win_sel;
          beat_d = '0;
          if (!wnr_q) begin
            state_d = RD_ISSUE;
            be_rd_d = 1'b1;
            ld_oe_d = 1'b1;
          end else begin
            state_d  = WR_BEAT;
            nready_d = 1'b0;
            nbterm_d = burst_new;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        lat_d   = '0;
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          state_d  = RD_BEAT;
          rdata_d  = be_rdat_i;
          nready_d = 1'b0;
          nbterm_d = !term_cond;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      WR_BEAT: begin
        state_d = WR_COMMIT;
        be_wr_d = 1'b1;
        wdat_d  = ld_q;
      end
      RD_BEAT, WR_COMMIT: begin
        if (!nblast_q || term_cond) begin
          state_d = IDLE;
          ld_oe_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
          beat_d = beat_nx;
          if (state_q == RD_BEAT) begin
            state_d = RD_ISSUE;
            be_rd_d = 1'b1;
          end else begin
            state_d  = WR_BEAT;
            nready_d = 1'b0;
            nbterm_d = !term_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && tmo_d == TMO_W'(TIMEOUT)) begin
      state_d  = IDLE;
      nready_d = 1'b1;
      nbterm_d = 1'b1;
      be_rd_d  = 1'b0;
      be_wr_d  = 1'b0;
      ld_oe_d  = 1'b0;
      tmo_d    = '0;
      err_d    = 1'b1;
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      win_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      tmo_q    <= '0;
      rdata_q  <= '0;
      wdat_q   <= '0;
      ld_oe_q  <= 1'b0;
      nready_q <= 1'b1;
      nbterm_q <= 1'b1;
      be_rd_q  <= 1'b0;
      be_wr_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      win_q    <= win_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
      wdat_q   <= wdat_d;
      ld_oe_q  <= ld_oe_d;
      nready_q <= nready_d;
      nbterm_q <= nbterm_d;
      be_rd_q  <= be_rd_d;
      be_wr_q  <= be_wr_d;
      err_q    <= err_d;
    end
  end

  assign ld_o      = rdata_q;
  assign ld_oe_o   = ld_oe_q;
  assign nready_o  = nready_q;
  assign nbterm_o  = nbterm_q;
  assign win_o     = win_q;
  assign be_addr_o = addr_q;
  assign be_rd_o   = be_rd_q;
  assign be_wr_o   = be_wr_q;
  assign be_wdat_o = wdat_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_lbus_slave_v3.sv
// Bench for lbus_slave_v3: table of bus transfers with hand-computed
// beat counts, terminate beats and windows, plus hand sequences for
// ignored strobes, asynchronous reset and the timeout flag.
module tb_lbus_slave_v3;

  localparam int RD_LAT = 2;

  // Clock / reset
  logic clk_i = 1'b0;
  logic nrst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        nads_i = 1'b1, wnr_i = 1'b0, nblast_i = 1'b1, err_clr_i = 1'b0;
  logic [2:0]  ncs_i = 3'b111, burst_en_i = 3'b111;
  logic [5:0]  la_i = '0;
  logic [31:0] ld_i = '0;
  logic [31:0] be_rdat_i;

  logic [31:0] ld_o, be_wdat_o;
  logic        ld_oe_o, nready_o, nbterm_o, be_rd_o, be_wr_o, err_o;
  logic [1:0]  win_o;
  logic [5:0]  be_addr_o;

  logic [31:0] d2_ld_o, d2_be_wdat_o;
  logic        d2_ld_oe_o, d2_nready_o, d2_nbterm_o, d2_be_rd_o, d2_be_wr_o, d2_err_o;
  logic [1:0]  d2_win_o;
  logic [5:0]  d2_be_addr_o;

  lbus_slave_v3 #(.RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .nads_i(nads_i), .wnr_i(wnr_i),
    .nblast_i(nblast_i), .ncs_i(ncs_i), .la_i(la_i), .ld_i(ld_i),
    .ld_o(ld_o), .ld_oe_o(ld_oe_o), .nready_o(nready_o), .nbterm_o(nbterm_o),
    .burst_en_i(burst_en_i), .win_o(win_o), .be_addr_o(be_addr_o),
    .be_rd_o(be_rd_o), .be_rdat_i(be_rdat_i), .be_wr_o(be_wr_o),
    .be_wdat_o(be_wdat_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  // Slow-backend instance with a short timeout
  lbus_slave_v3 #(.RD_LAT(7), .TIMEOUT(8)) dut2 (
    .clk_i(clk_i), .nrst_i(nrst_i), .nads_i(nads_i), .wnr_i(wnr_i),
    .nblast_i(nblast_i), .ncs_i(ncs_i), .la_i(la_i), .ld_i(ld_i),
    .ld_o(d2_ld_o), .ld_oe_o(d2_ld_oe_o), .nready_o(d2_nready_o), .nbterm_o(d2_nbterm_o),
    .burst_en_i(burst_en_i), .win_o(d2_win_o), .be_addr_o(d2_be_addr_o),
    .be_rd_o(d2_be_rd_o), .be_rdat_i(32'h0), .be_wr_o(d2_be_wr_o),
    .be_wdat_o(d2_be_wdat_o), .err_o(d2_err_o), .err_clr_i(err_clr_i)
  );

  // Backend model: data valid exactly RD_LAT clocks after the read strobe
  logic       rp_v [1:RD_LAT];
  logic [5:0] rp_a [1:RD_LAT];
  always @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 1; i <= RD_LAT; i++) begin rp_v[i] <= 1'b0; rp_a[i] <= '0; end
    end else begin
      rp_v[1] <= be_rd_o;
      rp_a[1] <= be_addr_o;
      for (int i = 2; i <= RD_LAT; i++) begin rp_v[i] <= rp_v[i-1]; rp_a[i] <= rp_a[i-1]; end
    end
  end

  function automatic logic [31:0] rd_data(input logic [5:0] a);
    return {16'hC0DE, 10'h0, a};
  endfunction

  assign be_rdat_i = rp_v[RD_LAT] ? rd_data(rp_a[RD_LAT]) : 32'h0BAD_0BAD;

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nready"}, {31'b0, nready_o}, 32'd1);
    chk({tag, "_nbterm"}, {31'b0, nbterm_o}, 32'd1);
    chk({tag, "_ld_oe"},  {31'b0, ld_oe_o},  32'd0);
    chk({tag, "_be_rd"},  {31'b0, be_rd_o},  32'd0);
    chk({tag, "_be_wr"},  {31'b0, be_wr_o},  32'd0);
    chk({tag, "_addr"},   {26'b0, be_addr_o}, 32'd0);
    chk({tag, "_win"},    {30'b0, win_o},    32'd0);
    chk({tag, "_ld_o"},   ld_o,              32'd0);
    chk({tag, "_wdat"},   be_wdat_o,         32'd0);
    chk({tag, "_err"},    {31'b0, err_o},    32'd0);
  endtask

  // Transfer vector: bus stimulus plus hand-computed expectations
  typedef struct {
    logic        wnr;
    logic [2:0]  ncs;
    logic [5:0]  la;
    logic [2:0]  ben;
    int          nbl_beat;   // beat on which master asserts nblast (99 = never)
    logic [31:0] dbase;      // write data for beat k is dbase + k
    int          inj;        // cycle of a spurious nads pulse (-1 = none)
    int          exp_beats;
    int          exp_bterm;  // beat with nbterm low (-1 = none)
    logic [1:0]  exp_win;
  } vec_t;

  task automatic run_vec(input int id, input vec_t v);
    int n_rd, n_wr, n_rdy, n_stray, last_rdy, win_len, gap;
    logic pend;
    logic [5:0] ea;
    n_rd = 0; n_wr = 0; n_rdy = 0; n_stray = 0; last_rdy = -1; pend = 1'b0;
    gap = v.wnr ? 2 : RD_LAT + 2;
    win_len = v.exp_beats * gap + 10;
    burst_en_i = v.ben;
    ncs_i = v.ncs; la_i = v.la; wnr_i = v.wnr; nads_i = 1'b0;
    nblast_i = (v.nbl_beat == 0) ? 1'b0 : 1'b1;
    ld_i = v.dbase;
    for (int cyc = 1; cyc <= win_len; cyc++) begin
      tick();
      if (pend) begin
        nblast_i = (n_rdy == v.nbl_beat) ? 1'b0 : 1'b1;
        ld_i = v.dbase + 32'(n_rdy);
        pend = 1'b0;
      end
      if (cyc == 1) nads_i = 1'b1;
      if (cyc == v.inj) begin nads_i = 1'b0; wnr_i = ~v.wnr; la_i = 6'h00; end
      if (cyc == v.inj + 1) begin nads_i = 1'b1; wnr_i = v.wnr; la_i = v.la; end
      if (be_rd_o) begin
        ea = v.la + 6'(n_rd);
        chk($sformatf("v%0d_rd_cyc", id), 32'(cyc), 32'(2 + gap * n_rd));
        chk($sformatf("v%0d_rd_addr", id), {26'b0, be_addr_o}, {26'b0, ea});
        n_rd++;
      end
      if (be_wr_o) begin
        ea = v.la + 6'(n_wr);
        chk($sformatf("v%0d_wr_cyc", id), 32'(cyc), 32'(3 + 2 * n_wr));
        chk($sformatf("v%0d_wr_addr", id), {26'b0, be_addr_o}, {26'b0, ea});
        chk($sformatf("v%0d_wr_data", id), be_wdat_o, v.dbase + 32'(n_wr));
        n_wr++;
      end
      if (!nready_o) begin
        ea = v.la + 6'(n_rdy);
        chk($sformatf("v%0d_rdy_cyc", id), 32'(cyc), 32'((v.wnr ? 2 : 5) + gap * n_rdy));
        chk($sformatf("v%0d_nbterm_b%0d", id, n_rdy), {31'b0, nbterm_o},
            (n_rdy == v.exp_bterm) ? 32'd0 : 32'd1);
        chk($sformatf("v%0d_win", id), {30'b0, win_o}, {30'b0, v.exp_win});
        chk($sformatf("v%0d_ld_oe", id), {31'b0, ld_oe_o}, v.wnr ? 32'd0 : 32'd1);
        if (!v.wnr) chk($sformatf("v%0d_ld_o", id), ld_o, rd_data(ea));
        last_rdy = cyc;
        n_rdy++;
        pend = 1'b1;
      end else if (!nbterm_o) begin
        n_stray++;
      end
      if (n_rdy == v.exp_beats && cyc == last_rdy + 1 && !v.wnr)
        chk($sformatf("v%0d_oe_drop", id), {31'b0, ld_oe_o}, 32'd0);
    end
    chk($sformatf("v%0d_beats", id), 32'(n_rdy), 32'(v.exp_beats));
    chk($sformatf("v%0d_n_rd", id), 32'(n_rd), v.wnr ? 32'd0 : 32'(v.exp_beats));
    chk($sformatf("v%0d_n_wr", id), 32'(n_wr), v.wnr ? 32'(v.exp_beats) : 32'd0);
    chk($sformatf("v%0d_stray_bterm", id), 32'(n_stray), 32'd0);
    nblast_i = 1'b1; ncs_i = 3'b111;
    repeat (4) tick();
  endtask

  vec_t vecs [9];
  int   act;

  initial begin
    // Table: wnr ncs la ben nbl dbase inj | beats bterm win
    vecs[0] = '{1'b0, 3'b110, 6'h05, 3'b111, 0,  32'h0,         -1, 1,  -1, 2'd0};
    vecs[1] = '{1'b0, 3'b110, 6'h3E, 3'b111, 3,  32'h0,         -1, 4,  -1, 2'd0};
    vecs[2] = '{1'b1, 3'b011, 6'h02, 3'b011, 99, 32'hDEADBEEF,  -1, 1,  0,  2'd2};
    vecs[3] = '{1'b1, 3'b110, 6'h38, 3'b111, 99, 32'h1000_0000, -1, 16, 15, 2'd0};
    vecs[4] = '{1'b0, 3'b101, 6'h10, 3'b010, 2,  32'h0,         -1, 3,  -1, 2'd1};
    vecs[5] = '{1'b1, 3'b000, 6'h20, 3'b001, 1,  32'hA5A5_0000, -1, 2,  -1, 2'd0};
    vecs[6] = '{1'b0, 3'b011, 6'h07, 3'b000, 99, 32'h0,         -1, 1,  0,  2'd2};
    vecs[7] = '{1'b0, 3'b110, 6'h00, 3'b111, 15, 32'h0,         -1, 16, 15, 2'd0};
    vecs[8] = '{1'b0, 3'b110, 6'h30, 3'b111, 1,  32'h0,         3,  2,  -1, 2'd0};

    // Reset state while reset is held
    #23;
    chk_reset_vals("rst");
    tick();
    nrst_i = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // nads with no chip select must be ignored
    ncs_i = 3'b111; wnr_i = 1'b0; nads_i = 1'b0; la_i = 6'h11;
    tick();
    nads_i = 1'b1;
    act = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (be_rd_o || be_wr_o || !nready_o || ld_oe_o) act++;
    end
    chk("nocs_ignored", 32'(act), 32'd0);

    // Reset asserted mid-burst takes effect immediately
    burst_en_i = 3'b111; ncs_i = 3'b101; la_i = 6'h21; wnr_i = 1'b0;
    nblast_i = 1'b1; nads_i = 1'b0;
    tick();
    nads_i = 1'b1;
    repeat (5) tick();
    chk("mid_ld_oe", {31'b0, ld_oe_o}, 32'd1);
    chk("mid_win", {30'b0, win_o}, 32'd1);
    chk("mid_ld_o", ld_o, rd_data(6'h21));
    #2;
    nrst_i = 1'b0;
    #1;
    chk_reset_vals("async");
    ncs_i = 3'b111;
    repeat (2) tick();
    nrst_i = 1'b1;
    repeat (6) tick();
    chk("post_rst_nready", {31'b0, nready_o}, 32'd1);
    chk("post_rst_be_rd", {31'b0, be_rd_o}, 32'd0);

    // Timeout on the slow instance: read never served within 8 clocks
    chk("tmo_err_init", {31'b0, d2_err_o}, 32'd0);
    ncs_i = 3'b110; la_i = 6'h00; wnr_i = 1'b0; nblast_i = 1'b0; nads_i = 1'b0;
    act = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc == 1) nads_i = 1'b1;
      if (!d2_nready_o) act++;
      if (cyc == 2) chk("tmo_be_rd", {31'b0, d2_be_rd_o}, 32'd1);
      if (cyc == 9) begin
        chk("tmo_err_before", {31'b0, d2_err_o}, 32'd0);
        chk("tmo_oe_before", {31'b0, d2_ld_oe_o}, 32'd1);
      end
    end
    chk("tmo_err_set", {31'b0, d2_err_o}, 32'd1);
    chk("tmo_oe_off", {31'b0, d2_ld_oe_o}, 32'd0);
    chk("tmo_no_ready", 32'(act), 32'd0);
    repeat (5) tick();
    chk("tmo_err_sticky", {31'b0, d2_err_o}, 32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("tmo_err_clr", {31'b0, d2_err_o}, 32'd0);
    repeat (3) tick();

    // Timeout and clear on the same clock: set wins
    nads_i = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc == 1) nads_i = 1'b1;
      err_clr_i = (cyc == 9) ? 1'b1 : 1'b0;
    end
    chk("tmo_set_wins", {31'b0, d2_err_o}, 32'd1);
    chk("main_err_clear", {31'b0, err_o}, 32'd0);
    nblast_i = 1'b1; ncs_i = 3'b111;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
